top_cpu: RTL and testbench
==========================

Name: top_cpu

Overview:
- Self-contained 8-bit accumulator processor that serves as the design's top-level block.
- Contains a fixed 16-word instruction ROM, a 16x8 data RAM, an accumulator, Z/C flags and a program counter.
- After reset it runs a built-in program that sums 5+4+3+2+1. It emits the result once on a debug output port, then halts.
- All outputs are observation-only, so the block works with only clk and reset connected.

Parameters:
- None. Widths are fixed: 8-bit data, 4-bit addresses, 8-bit instructions.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_o  output  4  current program counter.
- acc_o  output  8  accumulator.
- zero_o  output  1  Z flag.
- carry_o  output  1  C flag.
- out_data  output  8  last value written by OUT.
- out_valid  output  1  one-cycle pulse when OUT executes.
- halted_o  output  1  high once HLT has executed.

Behaviour:
- Reset (reset=0, asynchronous): pc=0, acc=0, Z=0, C=0, all 16 RAM words=0, out_data=0, out_valid=0, halted=0.
- Execution timing:
  - Single-cycle: each rising edge with reset=1 and halted=0 executes ROM[pc].
  - pc becomes pc+1 (4-bit wrap 15->0) unless a jump is taken.
- Instruction format: op=instr[7:4], k=instr[3:0]. k is an immediate (zero-extended) or a RAM address.
- Opcodes:
  - 0 NOP: no operation.
  - 1 LDI: acc=k.
  - 2 LDA: acc=RAM[k].
  - 3 STA: RAM[k]=acc.
  - 4 ADD: acc=acc+RAM[k].
  - 5 SUB: acc=acc-RAM[k].
  - 6 AND, 7 OR, 8 XOR: acc = acc op RAM[k].
  - 9 JMP k: pc=k.
  - A JZ k: pc=k if Z=1.
  - B JC k: pc=k if C=1.
  - C ADDI: acc=acc+k.
  - D SUBI: acc=acc-k.
  - E OUT: out_data=acc, out_valid=1 for that cycle only.
  - F HLT: halted=1, pc frozen.
- Flags:
  - Z = (new acc==0), updated by LDI, LDA and ops 4-8, C, D.
  - C is updated by ops 4, 5, C, D only. ADD/ADDI: carry out of bit 7. SUB/SUBI: borrow (1 when minuend < subtrahend).
  - All other instructions leave flags unchanged.
- Halted state: all state frozen until reset; out_valid stays 0.
- RAM: written synchronously; read combinationally within the same cycle.
- ROM program (address: instruction):
  - 0 LDI 5; 1 STA 0; 2 LDI 0; 3 STA 1
  - 4 LDA 1; 5 ADD 0; 6 STA 1; 7 LDA 0
  - 8 SUBI 1; 9 STA 0; 10 JZ 12; 11 JMP 4
  - 12 LDA 1; 13 OUT; 14 HLT; 15 NOP
- Program timeline: 46 instructions execute. out_valid pulses on edge 45 with out_data=0x0F. halted_o rises on edge 46 with pc_o=14.
- Reset asserted mid-run: immediate return to reset values; the program restarts from pc=0 after release.

Decomposition:
- Package top_cpu_pkg: opcode localparams (OP_NOP..OP_HLT) and the ROM contents function/constant.
- Sub-module top_cpu_alu: combinational 8-bit ALU.
  - Inputs: op, a, b.
  - Outputs: result, carry, z_update, c_update.
- Top holds pc, acc, flags, RAM, output registers and the halt logic.

Test Plan:
- Reset check: hold reset=0 for 2 cycles -> pc_o=0, acc_o=0, zero_o=0, carry_o=0, out_valid=0, out_data=0x00, halted_o=0.
- Early trace: release reset, count rising edges.
  - After 1 edge: acc_o=0x05.
  - After 6 edges: acc_o=0x05, pc_o=6.
  - After 10 edges: pc_o=10, zero_o=0, carry_o=0.
  - After 11 edges: pc_o=11, i.e. JZ not taken.
- Full run:
  - out_valid high only after edge 45, with out_data=0x0F and acc_o=0x0F.
  - After edge 46: halted_o=1, pc_o=14.
- Halt hold: 20 further clocks after halt -> pc_o=14, acc_o=0x0F, out_data=0x0F, out_valid=0, halted_o=1, all unchanged.
- Mid-run reset: drive reset=0 asynchronously (between edges) at edge 20 -> outputs go to reset values immediately. Release -> identical 46-edge sequence and result 0x0F (RAM was cleared).
- ALU unit check on top_cpu_alu:
  - ADD 0xFF+0x01 -> result 0x00, C=1, Z=1.
  - SUB 0x03-0x05 -> result 0xFE, C=1.
  - SUBI 0x01-1 -> result 0x00, Z=1, C=0.

Source files
------------

// File: rtl/top_cpu_pkg.sv
// top_cpu_pkg: shared definitions for the top_cpu accumulator processor.
//   - 4-bit opcode constants (instr[7:4])
//   - rom_word(): the fixed 16-word program that sums 5+4+3+2+1, then
//     emits the result with OUT and stops with HLT.
package top_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_SUBI = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // RAM[0] holds the down-counter, RAM[1] the running sum.
  function automatic logic [7:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = {OP_LDI,  4'd5};
      4'd1:    rom_word = {OP_STA,  4'd0};
      4'd2:    rom_word = {OP_LDI,  4'd0};
      4'd3:    rom_word = {OP_STA,  4'd1};
      4'd4:    rom_word = {OP_LDA,  4'd1};
      4'd5:    rom_word = {OP_ADD,  4'd0};
      4'd6:    rom_word = {OP_STA,  4'd1};
      4'd7:    rom_word = {OP_LDA,  4'd0};
      4'd8:    rom_word = {OP_SUBI, 4'd1};
      4'd9:    rom_word = {OP_STA,  4'd0};
      4'd10:   rom_word = {OP_JZ,   4'd12};
      4'd11:   rom_word = {OP_JMP,  4'd4};
      4'd12:   rom_word = {OP_LDA,  4'd1};
      4'd13:   rom_word = {OP_OUT,  4'd0};
      4'd14:   rom_word = {OP_HLT,  4'd0};
      default: rom_word = {OP_NOP,  4'd0};
    endcase
  endfunction

endpackage

// File: rtl/top_cpu_alu.sv
// top_cpu_alu: combinational 8-bit ALU for top_cpu.
// Ports:
//   op       in  4  opcode
//   a        in  8  accumulator operand
//   b        in  8  RAM word or zero-extended immediate (selected by caller)
//   result   out 8  new accumulator value (meaningful when z_update=1)
//   carry    out 1  carry out of bit 7 (add) or borrow (sub)
//   z_update out 1  this opcode writes acc and Z
//   c_update out 1  this opcode writes C
module top_cpu_alu
  import top_cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry,
  output logic       z_update,
  output logic       c_update
);

  logic [8:0] wide;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    result   = a;
    carry    = 1'b0;
    z_update = 1'b0;
    c_update = 1'b0;
    wide     = '0;
    case (op)
      OP_LDI, OP_LDA: begin
        result   = b;
        z_update = 1'b1;
      end
      OP_ADD, OP_ADDI: begin
        wide     = {1'b0, a} + {1'b0, b};
        result   = wide[7:0];
        carry    = wide[8];
        z_update = 1'b1;
        c_update = 1'b1;
      end
      OP_SUB, OP_SUBI: begin
        // Bit 8 of the 9-bit difference is set exactly when a < b (borrow).
        wide     = {1'b0, a} - {1'b0, b};
        result   = wide[7:0];
        carry    = wide[8];
        z_update = 1'b1;
        c_update = 1'b1;
      end
      OP_AND: begin
        result   = a & b;
        z_update = 1'b1;
      end
      OP_OR: begin
        result   = a | b;
        z_update = 1'b1;
      end
      OP_XOR: begin
        result   = a ^ b;
        z_update = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/top_cpu.sv
// top_cpu: single-cycle 8-bit accumulator processor with built-in program.
// Ports:
//   clk       in  1  system clock, rising edge
//   reset     in  1  asynchronous active-low reset
//   pc_o      out 4  program counter
//   acc_o     out 8  accumulator
//   zero_o    out 1  Z flag
//   carry_o   out 1  C flag
//   out_data  out 8  value captured by the last OUT
//   out_valid out 1  one-cycle pulse on the edge OUT executes
//   halted_o  out 1  set by HLT, cleared only by reset
module top_cpu
  import top_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] pc_o,
  output logic [7:0] acc_o,
  output logic       zero_o,
  output logic       carry_o,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       halted_o
);

  logic [3:0] pc;
  logic [7:0] acc;
  logic       zero;
  logic       carry;
  logic       halted;
  logic [7:0] ram [16];

  logic [7:0] instr;
  logic [3:0] op;
  logic [3:0] k;
  logic [7:0] operand;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       z_update;
  logic       c_update;
  logic [3:0] pc_next;

  assign instr = rom_word(pc);
  assign op    = instr[7:4];
  assign k     = instr[3:0];

  // Immediate forms use k zero-extended; all others read RAM in the same cycle.
  assign operand = (op == OP_LDI || op == OP_ADDI || op == OP_SUBI)
                   ? {4'd0, k} : ram[k];

  top_cpu_alu u_alu (
    .op       (op),
    .a        (acc),
    .b        (operand),
    .result   (alu_result),
    .carry    (alu_carry),
    .z_update (z_update),
    .c_update (c_update)
  );

  always_comb begin
    pc_next = pc + 4'd1;
    case (op)
      OP_JMP:  pc_next = k;
      OP_JZ:   if (zero)  pc_next = k;
      OP_JC:   if (carry) pc_next = k;
      OP_HLT:  pc_next = pc;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; e.g. STA stores the acc from before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      acc       <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      halted    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      // NOTE: the data RAM is cleared by reset on purpose, so a mid-run reset
      // restarts the program from a known memory image (flop-based storage).
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (!halted) begin
        pc <= pc_next;
        if (z_update) begin
          acc  <= alu_result;
          zero <= (alu_result == 8'd0);
        end
        if (c_update) carry <= alu_carry;
        if (op == OP_STA) ram[k] <= acc;
        if (op == OP_OUT) begin
          out_data  <= acc;
          out_valid <= 1'b1;
        end
        if (op == OP_HLT) halted <= 1'b1;
      end
    end
  end

  assign pc_o     = pc;
  assign acc_o    = acc;
  assign zero_o   = zero;
  assign carry_o  = carry;
  assign halted_o = halted;

endmodule

// File: tb/tb_top_cpu.sv
// tb_top_cpu: self-checking bench for top_cpu and its ALU.
// An instruction-level interpreter of the program tracks the expected
// architectural state edge by edge; resets are asserted at random points.
module tb_top_cpu;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pc_o;
  logic [7:0] acc_o;
  logic       zero_o;
  logic       carry_o;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted_o;

  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_z_update;
  logic       alu_c_update;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  top_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .pc_o      (pc_o),
    .acc_o     (acc_o),
    .zero_o    (zero_o),
    .carry_o   (carry_o),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted_o  (halted_o)
  );

  top_cpu_alu alu (
    .op       (alu_op),
    .a        (alu_a),
    .b        (alu_b),
    .result   (alu_result),
    .carry    (alu_carry),
    .z_update (alu_z_update),
    .c_update (alu_c_update)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: ISA interpreter ----------------
  int prog [16];
  int m_pc, m_acc, m_out, m_z, m_c, m_ov, m_halt;
  int m_ram [16];
  int edge_no;

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_out = 0; m_z = 0; m_c = 0; m_ov = 0; m_halt = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
  endtask

  task automatic model_step();
    int op, k, v, npc;
    m_ov = 0;
    if (m_halt != 0) return;
    op  = prog[m_pc] / 16;
    k   = prog[m_pc] % 16;
    v   = m_ram[k];
    npc = (m_pc + 1) % 16;
    case (op)
      1:  m_acc = k;
      2:  m_acc = v;
      3:  m_ram[k] = m_acc;
      4:  begin m_c = (m_acc + v > 255); m_acc = (m_acc + v) % 256; end
      5:  begin m_c = (m_acc < v); m_acc = (m_acc - v + 256) % 256; end
      6:  m_acc = m_acc & v;
      7:  m_acc = m_acc | v;
      8:  m_acc = m_acc ^ v;
      9:  npc = k;
      10: if (m_z != 0) npc = k;
      11: if (m_c != 0) npc = k;
      12: begin m_c = (m_acc + k > 255); m_acc = (m_acc + k) % 256; end
      13: begin m_c = (m_acc < k); m_acc = (m_acc - k + 256) % 256; end
      14: begin m_out = m_acc; m_ov = 1; end
      15: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    if (op == 1 || op == 2 || (op >= 4 && op <= 8) || op == 12 || op == 13)
      m_z = (m_acc == 0);
    m_pc = npc;
  endtask

  task automatic compare_all(input string where);
    check({where, " pc"},        pc_o,      m_pc);
    check({where, " acc"},       acc_o,     m_acc);
    check({where, " zero"},      zero_o,    m_z);
    check({where, " carry"},     carry_o,   m_c);
    check({where, " out_data"},  out_data,  m_out);
    check({where, " out_valid"}, out_valid, m_ov);
    check({where, " halted"},    halted_o,  m_halt);
  endtask

  task automatic check_reset_values(input string where);
    check({where, " rst pc"},        pc_o,      4'd0);
    check({where, " rst acc"},       acc_o,     8'h00);
    check({where, " rst zero"},      zero_o,    1'b0);
    check({where, " rst carry"},     carry_o,   1'b0);
    check({where, " rst out_valid"}, out_valid, 1'b0);
    check({where, " rst out_data"},  out_data,  8'h00);
    check({where, " rst halted"},    halted_o,  1'b0);
  endtask

  // Advance n rising edges, checking the model and the known program milestones.
  task automatic run_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_no++;
      model_step();
      compare_all($sformatf("e%0d", edge_no));
      case (edge_no)
        1:  check("e1 acc=5", acc_o, 8'h05);
        6:  begin check("e6 acc=5", acc_o, 8'h05); check("e6 pc=6", pc_o, 4'd6); end
        10: begin
          check("e10 pc=10", pc_o, 4'd10);
          check("e10 z=0", zero_o, 1'b0);
          check("e10 c=0", carry_o, 1'b0);
        end
        11: check("e11 jz not taken", pc_o, 4'd11);
        45: begin
          check("e45 out_valid", out_valid, 1'b1);
          check("e45 out_data", out_data, 8'h0F);
          check("e45 acc", acc_o, 8'h0F);
        end
        46: begin check("e46 halted", halted_o, 1'b1); check("e46 pc", pc_o, 4'd14); end
        default: if (edge_no > 46) begin
          check("hold pc", pc_o, 4'd14);
          check("hold acc", acc_o, 8'h0F);
          check("hold out_data", out_data, 8'h0F);
          check("hold out_valid", out_valid, 1'b0);
          check("hold halted", halted_o, 1'b1);
        end else if (edge_no != 45) begin
          check($sformatf("e%0d no pulse", edge_no), out_valid, 1'b0);
        end
      endcase
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset   = 1'b1;
    edge_no = 0;
  endtask

  // Assert reset between edges after 'at' edges of a fresh run.
  task automatic midrun_reset(input int at);
    run_edges(at);
    #($urandom_range(1, 3));
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values($sformatf("async@%0d", at));
    @(posedge clk);
    #1;
    check_reset_values($sformatf("held@%0d", at));
    release_reset();
    run_edges(46);
    check($sformatf("rerun@%0d result", at), out_data, 8'h0F);
    check($sformatf("rerun@%0d halted", at), halted_o, 1'b1);
  endtask

  // ALU reference: expected update enables and values for an opcode.
  task automatic alu_ref(input int op, input int a, input int b,
                         output int res, output int c, output int zu, output int cu);
    res = 0; c = 0;
    zu  = (op == 1 || op == 2 || (op >= 4 && op <= 8) || op == 12 || op == 13);
    cu  = (op == 4 || op == 5 || op == 12 || op == 13);
    case (op)
      1, 2:   res = b;
      4, 12:  begin res = (a + b) % 256; c = (a + b > 255); end
      5, 13:  begin res = (a - b + 256) % 256; c = (a < b); end
      6:      res = a & b;
      7:      res = a | b;
      8:      res = a ^ b;
      default: ;
    endcase
  endtask

  initial begin
    int r, c, zu, cu;
    prog = '{8'h15, 8'h30, 8'h10, 8'h31, 8'h21, 8'h40, 8'h31, 8'h20,
             8'hD1, 8'h30, 8'hAC, 8'h94, 8'h21, 8'hE0, 8'hF0, 8'h00};
    alu_op = 4'h0; alu_a = 8'h00; alu_b = 8'h00;

    // Reset state.
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("init");

    // Full run, then 20 clocks of halt hold.
    release_reset();
    run_edges(66);

    // Mid-run resets: edge 20, then a few random points.
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    release_reset();
    midrun_reset(20);
    for (int n = 0; n < 3; n++) begin
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      release_reset();
      midrun_reset($urandom_range(1, 45));
    end

    // ALU directed corners.
    alu_op = 4'h4; alu_a = 8'hFF; alu_b = 8'h01; #1;
    check("alu add ff+1 res", alu_result, 8'h00);
    check("alu add ff+1 c", alu_carry, 1'b1);
    check("alu add ff+1 z", alu_result == 8'h00, 1'b1);
    alu_op = 4'h5; alu_a = 8'h03; alu_b = 8'h05; #1;
    check("alu sub 3-5 res", alu_result, 8'hFE);
    check("alu sub 3-5 c", alu_carry, 1'b1);
    alu_op = 4'hD; alu_a = 8'h01; alu_b = 8'h01; #1;
    check("alu subi 1-1 res", alu_result, 8'h00);
    check("alu subi 1-1 z", alu_result == 8'h00, 1'b1);
    check("alu subi 1-1 c", alu_carry, 1'b0);

    // ALU random sweep.
    for (int n = 0; n < 64; n++) begin
      alu_op = 4'($urandom_range(0, 15));
      alu_a  = 8'($urandom_range(0, 255));
      alu_b  = 8'($urandom_range(0, 255));
      #1;
      alu_ref(alu_op, alu_a, alu_b, r, c, zu, cu);
      check($sformatf("alu op%0h z_update", alu_op), alu_z_update, zu);
      check($sformatf("alu op%0h c_update", alu_op), alu_c_update, cu);
      if (zu != 0)
        check($sformatf("alu op%0h %0h,%0h res", alu_op, alu_a, alu_b), alu_result, r);
      if (cu != 0)
        check($sformatf("alu op%0h %0h,%0h carry", alu_op, alu_a, alu_b), alu_carry, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
